// File: rtl/hack_kbd_pkg.sv
// hack_kbd_pkg: Hack special key codes, PS/2 scancode constants and ps2_key field layout
package hack_kbd_pkg;
  localparam logic [7:0] HK_NEWLINE = 8'd128, HK_BACKSPACE = 8'd129, HK_LEFT = 8'd130, HK_UP = 8'd131;
  localparam logic [7:0] HK_RIGHT = 8'd132, HK_DOWN = 8'd133, HK_HOME = 8'd134, HK_END = 8'd135;
  localparam logic [7:0] HK_PGUP = 8'd136, HK_PGDN = 8'd137, HK_INSERT = 8'd138, HK_DELETE = 8'd139;
  localparam logic [7:0] HK_ESC = 8'd140, HK_F1 = 8'd141, HK_F2 = 8'd142, HK_F3 = 8'd143;
  localparam logic [7:0] HK_F4 = 8'd144, HK_F5 = 8'd145, HK_F6 = 8'd146, HK_F7 = 8'd147;
  localparam logic [7:0] HK_F8 = 8'd148, HK_F9 = 8'd149, HK_F10 = 8'd150, HK_F11 = 8'd151, HK_F12 = 8'd152;
  localparam logic [7:0] SC_LSHIFT = 8'h12, SC_RSHIFT = 8'h59, SC_CAPS = 8'h58;
  localparam int PS2_TOGGLE = 10, PS2_MAKE = 9, PS2_EXT = 8;
  typedef struct packed {
    logic       make;
    logic       ext;
    logic [7:0] sc;
  } ps2_ev_t;
endpackage

// File: rtl/hack_kbd_decoder_if.sv
// hack_kbd_decoder_if: ps2_key event input and Hack keyboard outputs
interface hack_kbd_decoder_if;
  logic [10:0] ps2_key;
  logic [15:0] kbd;
  logic        kbd_strobe;
  logic        shift_o;
  logic        caps_o;
  modport master (output ps2_key, input kbd, kbd_strobe, shift_o, caps_o);
  modport slave (input ps2_key, output kbd, kbd_strobe, shift_o, caps_o);
endinterface

// File: rtl/hack_kbd_decoder_keymap.sv
// hack_kbd_keymap: combinational PS/2 set-2 scancode to Hack key code table, 0 = unmapped
module hack_kbd_keymap
  import hack_kbd_pkg::*;
(
  input  logic [7:0] sc,
  input  logic       ext,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] code
);
  logic [7:0] lo, hi;
  always_comb begin
    {lo, hi} = 16'h0000;
    if (ext)
      case (sc)
        8'h6B: lo = HK_LEFT;   8'h75: lo = HK_UP;     8'h74: lo = HK_RIGHT;  8'h72: lo = HK_DOWN;
        8'h6C: lo = HK_HOME;   8'h69: lo = HK_END;    8'h7D: lo = HK_PGUP;   8'h7A: lo = HK_PGDN;
        8'h70: lo = HK_INSERT; 8'h71: lo = HK_DELETE;
        default: lo = 8'h00;
      endcase
    else
      case (sc)
        8'h1C: lo = "a"; 8'h32: lo = "b"; 8'h21: lo = "c"; 8'h23: lo = "d"; 8'h24: lo = "e";
        8'h2B: lo = "f"; 8'h34: lo = "g"; 8'h33: lo = "h"; 8'h43: lo = "i"; 8'h3B: lo = "j";
        8'h42: lo = "k"; 8'h4B: lo = "l"; 8'h3A: lo = "m"; 8'h31: lo = "n"; 8'h44: lo = "o";
        8'h4D: lo = "p"; 8'h15: lo = "q"; 8'h2D: lo = "r"; 8'h1B: lo = "s"; 8'h2C: lo = "t";
        8'h3C: lo = "u"; 8'h2A: lo = "v"; 8'h1D: lo = "w"; 8'h22: lo = "x"; 8'h35: lo = "y";
        8'h1A: lo = "z";
        8'h16: {lo, hi} = "1!"; 8'h1E: {lo, hi} = "2@"; 8'h26: {lo, hi} = "3#"; 8'h25: {lo, hi} = "4$";
        8'h2E: {lo, hi} = "5%"; 8'h36: {lo, hi} = "6^"; 8'h3D: {lo, hi} = "7&"; 8'h3E: {lo, hi} = "8*";
        8'h46: {lo, hi} = "9("; 8'h45: {lo, hi} = "0)";
        8'h0E: {lo, hi} = "`~"; 8'h4E: {lo, hi} = "-_"; 8'h55: {lo, hi} = "=+"; 8'h54: {lo, hi} = "[{";
        8'h5B: {lo, hi} = "]}"; 8'h5D: {lo, hi} = {8'h5C, 8'h7C}; 8'h4C: {lo, hi} = ";:";
        8'h52: {lo, hi} = {8'h27, 8'h22};
        8'h41: {lo, hi} = ",<"; 8'h49: {lo, hi} = ".>"; 8'h4A: {lo, hi} = "/?";
        8'h29: lo = " ";
        8'h5A: lo = HK_NEWLINE; 8'h66: lo = HK_BACKSPACE; 8'h76: lo = HK_ESC;
        8'h05: lo = HK_F1; 8'h06: lo = HK_F2; 8'h04: lo = HK_F3;  8'h0C: lo = HK_F4;
        8'h03: lo = HK_F5; 8'h0B: lo = HK_F6; 8'h83: lo = HK_F7;  8'h0A: lo = HK_F8;
        8'h01: lo = HK_F9; 8'h09: lo = HK_F10; 8'h78: lo = HK_F11; 8'h07: lo = HK_F12;
        default: lo = 8'h00;
      endcase
  end
  assign code = (lo >= "a" && lo <= "z") ? ((shift ^ caps) ? lo - 8'd32 : lo)
                                         : ((shift && hi != 8'h00) ? hi : lo);
endmodule

// File: rtl/hack_kbd_decoder.sv
// hack_kbd_decoder: turns hps_io ps2_key toggle events into the Hack KBD value with Shift/Caps tracking
module hack_kbd_decoder
  import hack_kbd_pkg::*;
#(
  parameter bit CAPS_ENABLE   = 1'b1,
  parameter bit REPEAT_STROBE = 1'b0
) (
  input logic               clk,
  input logic               reset_n,
  hack_kbd_decoder_if.slave bus
);
  logic       armed, toggle_q, evt_q;
  ps2_ev_t    ev_q;
  logic       lshift, rshift, caps_q, strobe_q;
  logic [7:0] kbd_q, code;
  logic [8:0] held;
  logic       is_l, is_r, is_caps;
  hack_kbd_keymap u_keymap (
    .sc   (ev_q.sc),
    .ext  (ev_q.ext),
    .shift(lshift | rshift),
    .caps (caps_q),
    .code (code)
  );
  // armed keeps the first post-reset sample from comparing against a stale toggle
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      {armed, toggle_q, evt_q} <= 3'b000;
      ev_q <= '0;
    end else begin
      armed    <= 1'b1;
      toggle_q <= bus.ps2_key[PS2_TOGGLE];
      evt_q    <= armed && (bus.ps2_key[PS2_TOGGLE] != toggle_q);
      ev_q     <= '{make: bus.ps2_key[PS2_MAKE], ext: bus.ps2_key[PS2_EXT], sc: bus.ps2_key[7:0]};
    end
  assign is_l    = !ev_q.ext && ev_q.sc == SC_LSHIFT;
  assign is_r    = !ev_q.ext && ev_q.sc == SC_RSHIFT;
  assign is_caps = !ev_q.ext && ev_q.sc == SC_CAPS;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      {lshift, rshift, caps_q, strobe_q} <= 4'b0000;
      kbd_q <= 8'h00;
      held  <= 9'h000;
    end else begin
      strobe_q <= 1'b0;
      if (evt_q) begin
        if (is_l) lshift <= ev_q.make;
        else if (is_r) rshift <= ev_q.make;
        else if (is_caps) begin
          if (ev_q.make && CAPS_ENABLE) caps_q <= !caps_q;
        end else if (ev_q.make) begin
          if (code != 8'h00 && code != kbd_q) begin
            kbd_q    <= code;
            held     <= {ev_q.ext, ev_q.sc};
            strobe_q <= 1'b1;
          end else if (code != 8'h00) strobe_q <= REPEAT_STROBE;
        end else if ({ev_q.ext, ev_q.sc} == held) begin
          kbd_q    <= 8'h00;
          held     <= 9'h000;
          strobe_q <= kbd_q != 8'h00;
        end
      end
    end
  assign bus.kbd        = {8'h00, kbd_q};
  assign bus.kbd_strobe = strobe_q;
  assign bus.shift_o    = lshift | rshift;
  assign bus.caps_o     = caps_q;
endmodule
